// File: rtl/axicb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axicb_pkg
// Description : Shared constants for the crossbar master interface. Holds the
//               AXI_SIGNALING packing modes, the AXI sideband field widths and
//               a helper that returns the packed AW/AR channel width per mode.
// Revision    : 1.0 - initial release
// ============================================================================
package axicb_pkg;

  // Channel packing modes selected by AXI_SIGNALING
  typedef enum logic [1:0] {
    SIG_LITE = 2'd0,  // {id,prot,addr}
    SIG_LEN  = 2'd1,  // {id,prot,len,addr}
    SIG_FULL = 2'd2   // {id,region,qos,prot,cache,lock,burst,size,len,addr}
  } axi_signaling_e;

  localparam int AXI_SIG_LITE = 0;
  localparam int AXI_SIG_LEN  = 1;
  localparam int AXI_SIG_FULL = 2;

  // AXI sideband field widths
  localparam int LEN_W    = 8;
  localparam int SIZE_W   = 3;
  localparam int BURST_W  = 2;
  localparam int LOCK_W   = 1;
  localparam int CACHE_W  = 4;
  localparam int PROT_W   = 3;
  localparam int QOS_W    = 4;
  localparam int REGION_W = 4;
  localparam int RESP_W   = 2;

  // Packed AW/AR channel width for a given packing mode
  function automatic int axich_w(input int signaling, input int addr_w, input int id_w);
    if (signaling == AXI_SIG_LITE)
      return id_w + PROT_W + addr_w;
    else if (signaling == AXI_SIG_LEN)
      return id_w + PROT_W + LEN_W + addr_w;
    else
      return id_w + REGION_W + QOS_W + PROT_W + CACHE_W + LOCK_W + BURST_W
             + SIZE_W + LEN_W + addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axicb_ostd_cnt.sv
`default_nettype none
// ============================================================================
// Module      : axicb_ostd_cnt
// Description : One outstanding-request counter with full flag, saturation at
//               zero with a sticky protocol-error flag, and an optional stall
//               timer (enabled by the AXICB_MST_TIMEOUT_EN macro).
// Revision    : 1.0 - initial release
// Ports       : clk, rst          clock / asynchronous active-high reset
//               inc               request handshake (never asserted when full)
//               dec               completion handshake
//               timeout_clr       synchronous clear of the timeout flag
//               cnt               live outstanding count
//               full              cnt == MAX_OSTD (registered-count based)
//               proto_err         sticky: completion seen with cnt == 0
//               timeout           sticky stall flag (0 without the macro)
// ============================================================================
module axicb_ostd_cnt #(
  parameter int MAX_OSTD       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(MAX_OSTD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             timeout_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             proto_err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OSTD);

  assign full = (cnt == CNT_MAX);

  // Simultaneous request and completion cancel out; a completion with no
  // outstanding request leaves the count at zero and flags the violation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      if (dec && (cnt == '0))
        proto_err <= 1'b1;
      if (inc && !dec)
        cnt <= cnt + CNT_W'(1);
      else if (dec && !inc && (cnt != '0))
        cnt <= cnt - CNT_W'(1);
    end
  end

`ifdef AXICB_MST_TIMEOUT_EN
  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer;
  logic             timer_run;
  logic             timer_expire;
  logic             timeout_q;

  // Timer only advances while something is pending and no progress is made
  assign timer_run    = (cnt != '0) && !dec;
  // Fires once, on the step that brings the timer to the threshold; the timer
  // then parks at the threshold so a clear is not immediately overridden.
  assign timer_expire = timer_run && (timer == TMR_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!timer_run)
        timer <= '0;
      else if (timer != TMR_MAX)
        timer <= timer + TMR_W'(1);

      if (timer_expire)
        timeout_q <= 1'b1;
      else if (timeout_clr)
        timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_clr & (TIMEOUT_CYCLES > 1);
  assign timeout        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/axicb_mst_if_ostd.sv
`default_nettype none
// ============================================================================
// Module      : axicb_mst_if_ostd
// Description : Master-side crossbar interface. Packs the master AXI channels
//               into the switch's concatenated buses, limits outstanding
//               requests per direction, holds W until its AW is accepted and
//               flags stalled transactions.
// Revision    : 1.0 - initial release
// Macro       : AXICB_MST_TIMEOUT_EN enables the per-direction stall timers;
//               without it o_wr_timeout / o_rd_timeout are constant 0.
// Ports       : aclk, arst              clock / async active-high reset
//               i_aw*, i_w*, i_b*       external master write channels
//               i_ar*, i_r*             external master read channels
//               o_aw*, o_w*, o_b*       packed switch-side write channels
//               o_ar*, o_r*             packed switch-side read channels
//               o_wr_ostd, o_rd_ostd    live outstanding counts
//               o_proto_err             sticky: response with count 0
//               o_wr/rd_timeout         sticky stall flags
//               i_timeout_clr           synchronous clear of stall flags
// ============================================================================
module axicb_mst_if_ostd
  import axicb_pkg::*;
#(
  parameter int AXI_ADDR_W      = 8,
  parameter int AXI_ID_W        = 8,
  parameter int AXI_DATA_W      = 8,
  parameter int AXI_SIGNALING   = 0,
  parameter int MST_OSTDREQ_NUM = 4,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int AWCH_W          = axich_w(AXI_SIGNALING, AXI_ADDR_W, AXI_ID_W),
  parameter int WCH_W           = AXI_DATA_W + AXI_DATA_W / 8,
  parameter int BCH_W           = AXI_ID_W + 2,
  parameter int ARCH_W          = axich_w(AXI_SIGNALING, AXI_ADDR_W, AXI_ID_W),
  parameter int RCH_W           = AXI_ID_W + 2 + AXI_DATA_W
) (
  input  logic                                       aclk,
  input  logic                                       arst,
  // master AW
  input  logic                                       i_awvalid,
  output logic                                       i_awready,
  input  logic [AXI_ADDR_W-1:0]                      i_awaddr,
  input  logic [7:0]                                 i_awlen,
  input  logic [2:0]                                 i_awsize,
  input  logic [1:0]                                 i_awburst,
  input  logic                                       i_awlock,
  input  logic [3:0]                                 i_awcache,
  input  logic [2:0]                                 i_awprot,
  input  logic [3:0]                                 i_awqos,
  input  logic [3:0]                                 i_awregion,
  input  logic [AXI_ID_W-1:0]                        i_awid,
  // master W
  input  logic                                       i_wvalid,
  output logic                                       i_wready,
  input  logic                                       i_wlast,
  input  logic [AXI_DATA_W-1:0]                      i_wdata,
  input  logic [AXI_DATA_W/8-1:0]                    i_wstrb,
  // master B
  output logic                                       i_bvalid,
  input  logic                                       i_bready,
  output logic [AXI_ID_W-1:0]                        i_bid,
  output logic [1:0]                                 i_bresp,
  // master AR
  input  logic                                       i_arvalid,
  output logic                                       i_arready,
  input  logic [AXI_ADDR_W-1:0]                      i_araddr,
  input  logic [7:0]                                 i_arlen,
  input  logic [2:0]                                 i_arsize,
  input  logic [1:0]                                 i_arburst,
  input  logic                                       i_arlock,
  input  logic [3:0]                                 i_arcache,
  input  logic [2:0]                                 i_arprot,
  input  logic [3:0]                                 i_arqos,
  input  logic [3:0]                                 i_arregion,
  input  logic [AXI_ID_W-1:0]                        i_arid,
  // master R
  output logic                                       i_rvalid,
  input  logic                                       i_rready,
  output logic [AXI_ID_W-1:0]                        i_rid,
  output logic [1:0]                                 i_rresp,
  output logic [AXI_DATA_W-1:0]                      i_rdata,
  output logic                                       i_rlast,
  // switch side
  output logic                                       o_awvalid,
  input  logic                                       o_awready,
  output logic [AWCH_W-1:0]                          o_awch,
  output logic                                       o_wvalid,
  input  logic                                       o_wready,
  output logic                                       o_wlast,
  output logic [WCH_W-1:0]                           o_wch,
  input  logic                                       o_bvalid,
  output logic                                       o_bready,
  input  logic [BCH_W-1:0]                           o_bch,
  output logic                                       o_arvalid,
  input  logic                                       o_arready,
  output logic [ARCH_W-1:0]                          o_arch,
  input  logic                                       o_rvalid,
  output logic                                       o_rready,
  input  logic                                       o_rlast,
  input  logic [RCH_W-1:0]                           o_rch,
  // status
  output logic [$clog2(MST_OSTDREQ_NUM+1)-1:0]       o_wr_ostd,
  output logic [$clog2(MST_OSTDREQ_NUM+1)-1:0]       o_rd_ostd,
  output logic                                       o_proto_err,
  output logic                                       o_wr_timeout,
  output logic                                       o_rd_timeout,
  input  logic                                       i_timeout_clr
);

  localparam int CNT_W = $clog2(MST_OSTDREQ_NUM + 1);

  logic             wr_full;
  logic             rd_full;
  logic             wr_err;
  logic             rd_err;
  logic             aw_hs;
  logic             w_last_hs;
  logic             b_hs;
  logic             ar_hs;
  logic             r_last_hs;
  logic             w_open;
  logic [CNT_W-1:0] wburst_cnt;

  // --------------------------------------------------------------------------
  // Address channel packing
  // --------------------------------------------------------------------------
  generate
    if (AXI_SIGNALING == AXI_SIG_LITE) begin : g_pack_lite
      logic unused_fields;
      assign unused_fields = ^{i_awlen, i_awsize, i_awburst, i_awlock, i_awcache,
                               i_awqos, i_awregion, i_arlen, i_arsize, i_arburst,
                               i_arlock, i_arcache, i_arqos, i_arregion};
      assign o_awch = {i_awid, i_awprot, i_awaddr};
      assign o_arch = {i_arid, i_arprot, i_araddr};
    end else if (AXI_SIGNALING == AXI_SIG_LEN) begin : g_pack_len
      logic unused_fields;
      assign unused_fields = ^{i_awsize, i_awburst, i_awlock, i_awcache, i_awqos,
                               i_awregion, i_arsize, i_arburst, i_arlock,
                               i_arcache, i_arqos, i_arregion};
      assign o_awch = {i_awid, i_awprot, i_awlen, i_awaddr};
      assign o_arch = {i_arid, i_arprot, i_arlen, i_araddr};
    end else begin : g_pack_full
      assign o_awch = {i_awid, i_awregion, i_awqos, i_awprot, i_awcache, i_awlock,
                       i_awburst, i_awsize, i_awlen, i_awaddr};
      assign o_arch = {i_arid, i_arregion, i_arqos, i_arprot, i_arcache, i_arlock,
                       i_arburst, i_arsize, i_arlen, i_araddr};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Flow control. Gates use registered counts only, so no valid->ready loop.
  // Reset also forces the handshake outputs low combinationally.
  // --------------------------------------------------------------------------
  assign w_open    = (wburst_cnt != '0);

  assign o_awvalid = i_awvalid & ~wr_full & ~arst;
  assign i_awready = o_awready & ~wr_full & ~arst;
  assign o_wvalid  = i_wvalid  & w_open   & ~arst;
  assign i_wready  = o_wready  & w_open   & ~arst;
  assign o_arvalid = i_arvalid & ~rd_full & ~arst;
  assign i_arready = o_arready & ~rd_full & ~arst;

  // Pass-through
  assign o_wlast                    = i_wlast;
  assign o_wch                      = {i_wstrb, i_wdata};
  assign i_bvalid                   = o_bvalid;
  assign o_bready                   = i_bready;
  assign {i_bresp, i_bid}           = o_bch;
  assign i_rvalid                   = o_rvalid;
  assign o_rready                   = i_rready;
  assign i_rlast                    = o_rlast;
  assign {i_rresp, i_rid, i_rdata}  = o_rch;

  // Handshakes
  assign aw_hs     = o_awvalid & o_awready;
  assign w_last_hs = o_wvalid & o_wready & i_wlast;
  assign b_hs      = o_bvalid & i_bready;
  assign ar_hs     = o_arvalid & o_arready;
  assign r_last_hs = o_rvalid & i_rready & o_rlast;

  // --------------------------------------------------------------------------
  // W bursts whose AW has been accepted but whose last beat has not passed.
  // Bounded by the write count, so the same width is enough.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or posedge arst) begin
    if (arst)
      wburst_cnt <= '0;
    else if (aw_hs && !w_last_hs)
      wburst_cnt <= wburst_cnt + CNT_W'(1);
    else if (w_last_hs && !aw_hs)
      wburst_cnt <= wburst_cnt - CNT_W'(1);
  end

  // --------------------------------------------------------------------------
  // Outstanding counters
  // --------------------------------------------------------------------------
  axicb_ostd_cnt #(
    .MAX_OSTD       (MST_OSTDREQ_NUM),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wr_cnt (
    .clk         (aclk),
    .rst         (arst),
    .inc         (aw_hs),
    .dec         (b_hs),
    .timeout_clr (i_timeout_clr),
    .cnt         (o_wr_ostd),
    .full        (wr_full),
    .proto_err   (wr_err),
    .timeout     (o_wr_timeout)
  );

  axicb_ostd_cnt #(
    .MAX_OSTD       (MST_OSTDREQ_NUM),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rd_cnt (
    .clk         (aclk),
    .rst         (arst),
    .inc         (ar_hs),
    .dec         (r_last_hs),
    .timeout_clr (i_timeout_clr),
    .cnt         (o_rd_ostd),
    .full        (rd_full),
    .proto_err   (rd_err),
    .timeout     (o_rd_timeout)
  );

  assign o_proto_err = wr_err | rd_err;

endmodule
`default_nettype wire

// File: tb/tb_axicb_mst_if_ostd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_axicb_mst_if_ostd
// Description : Self-checking bench for axicb_mst_if_ostd (lite packing,
//               4 outstanding). Table of hand-computed vectors, randomized
//               traffic against a count-based reference model, and directed
//               corner-case sequences. Timeout sequence only when
//               AXICB_MST_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axicb_mst_if_ostd;

  localparam int AW     = 8;
  localparam int IW     = 8;
  localparam int DW     = 8;
  localparam int SW     = DW / 8;
  localparam int MAX    = 4;
  localparam int CW     = $clog2(MAX + 1);
  localparam int AWCH_W = IW + 3 + AW;
  localparam int WCH_W  = DW + SW;
  localparam int BCH_W  = IW + 2;
  localparam int RCH_W  = IW + 2 + DW;
`ifdef AXICB_MST_TIMEOUT_EN
  localparam int TMO    = 16;
`else
  localparam int TMO    = 1024;
`endif

  logic aclk = 1'b0;
  logic arst;
  always #5 aclk = ~aclk;

  logic              i_awvalid, i_awready;
  logic [AW-1:0]     i_awaddr;
  logic [7:0]        i_awlen;
  logic [2:0]        i_awsize;
  logic [1:0]        i_awburst;
  logic              i_awlock;
  logic [3:0]        i_awcache;
  logic [2:0]        i_awprot;
  logic [3:0]        i_awqos, i_awregion;
  logic [IW-1:0]     i_awid;
  logic              i_wvalid, i_wready, i_wlast;
  logic [DW-1:0]     i_wdata;
  logic [SW-1:0]     i_wstrb;
  logic              i_bvalid, i_bready;
  logic [IW-1:0]     i_bid;
  logic [1:0]        i_bresp;
  logic              i_arvalid, i_arready;
  logic [AW-1:0]     i_araddr;
  logic [7:0]        i_arlen;
  logic [2:0]        i_arsize;
  logic [1:0]        i_arburst;
  logic              i_arlock;
  logic [3:0]        i_arcache;
  logic [2:0]        i_arprot;
  logic [3:0]        i_arqos, i_arregion;
  logic [IW-1:0]     i_arid;
  logic              i_rvalid, i_rready, i_rlast;
  logic [IW-1:0]     i_rid;
  logic [1:0]        i_rresp;
  logic [DW-1:0]     i_rdata;
  logic              o_awvalid, o_awready;
  logic [AWCH_W-1:0] o_awch;
  logic              o_wvalid, o_wready, o_wlast;
  logic [WCH_W-1:0]  o_wch;
  logic              o_bvalid, o_bready;
  logic [BCH_W-1:0]  o_bch;
  logic              o_arvalid, o_arready;
  logic [AWCH_W-1:0] o_arch;
  logic              o_rvalid, o_rready, o_rlast;
  logic [RCH_W-1:0]  o_rch;
  logic [CW-1:0]     o_wr_ostd, o_rd_ostd;
  logic              o_proto_err, o_wr_timeout, o_rd_timeout, i_timeout_clr;

  axicb_mst_if_ostd #(
    .AXI_ADDR_W(AW), .AXI_ID_W(IW), .AXI_DATA_W(DW), .AXI_SIGNALING(0),
    .MST_OSTDREQ_NUM(MAX), .TIMEOUT_CYCLES(TMO),
    .AWCH_W(AWCH_W), .WCH_W(WCH_W), .BCH_W(BCH_W), .ARCH_W(AWCH_W), .RCH_W(RCH_W)
  ) dut (
    .aclk(aclk), .arst(arst),
    .i_awvalid(i_awvalid), .i_awready(i_awready), .i_awaddr(i_awaddr), .i_awlen(i_awlen),
    .i_awsize(i_awsize), .i_awburst(i_awburst), .i_awlock(i_awlock), .i_awcache(i_awcache),
    .i_awprot(i_awprot), .i_awqos(i_awqos), .i_awregion(i_awregion), .i_awid(i_awid),
    .i_wvalid(i_wvalid), .i_wready(i_wready), .i_wlast(i_wlast), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb),
    .i_bvalid(i_bvalid), .i_bready(i_bready), .i_bid(i_bid), .i_bresp(i_bresp),
    .i_arvalid(i_arvalid), .i_arready(i_arready), .i_araddr(i_araddr), .i_arlen(i_arlen),
    .i_arsize(i_arsize), .i_arburst(i_arburst), .i_arlock(i_arlock), .i_arcache(i_arcache),
    .i_arprot(i_arprot), .i_arqos(i_arqos), .i_arregion(i_arregion), .i_arid(i_arid),
    .i_rvalid(i_rvalid), .i_rready(i_rready), .i_rid(i_rid), .i_rresp(i_rresp),
    .i_rdata(i_rdata), .i_rlast(i_rlast),
    .o_awvalid(o_awvalid), .o_awready(o_awready), .o_awch(o_awch),
    .o_wvalid(o_wvalid), .o_wready(o_wready), .o_wlast(o_wlast), .o_wch(o_wch),
    .o_bvalid(o_bvalid), .o_bready(o_bready), .o_bch(o_bch),
    .o_arvalid(o_arvalid), .o_arready(o_arready), .o_arch(o_arch),
    .o_rvalid(o_rvalid), .o_rready(o_rready), .o_rlast(o_rlast), .o_rch(o_rch),
    .o_wr_ostd(o_wr_ostd), .o_rd_ostd(o_rd_ostd), .o_proto_err(o_proto_err),
    .o_wr_timeout(o_wr_timeout), .o_rd_timeout(o_rd_timeout), .i_timeout_clr(i_timeout_clr)
  );

  int checks = 0;
  int errors = 0;

  // reference model: plain counts of open requests / unfinished W bursts
  int m_wr, m_wb, m_rd;
  bit m_perr;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  task automatic idle();
    i_awvalid = 0; o_awready = 0; i_wvalid = 0; o_wready = 0; i_wlast = 0;
    o_bvalid = 0; i_bready = 0; i_arvalid = 0; o_arready = 0;
    o_rvalid = 0; i_rready = 0; o_rlast = 0; i_timeout_clr = 0;
    i_awaddr = 0; i_awlen = 0; i_awsize = 0; i_awburst = 0; i_awlock = 0; i_awcache = 0;
    i_awprot = 0; i_awqos = 0; i_awregion = 0; i_awid = 0; i_wdata = 0; i_wstrb = 0;
    o_bch = 0; i_araddr = 0; i_arlen = 0; i_arsize = 0; i_arburst = 0; i_arlock = 0;
    i_arcache = 0; i_arprot = 0; i_arqos = 0; i_arregion = 0; i_arid = 0; o_rch = 0;
  endtask

  task automatic model_clear();
    m_wr = 0; m_wb = 0; m_rd = 0; m_perr = 0;
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic do_reset();
    idle();
    arst = 1'b1;
    #1;
    chk("rst_cnt", {o_wr_ostd, o_rd_ostd}, '0);
    chk("rst_flags", {o_proto_err, o_wr_timeout, o_rd_timeout}, '0);
    @(posedge aclk); #1;
    arst = 1'b0;
    model_clear();
  endtask

  // One model-checked cycle with the inputs currently driven.
  task automatic cycle();
    bit e_awv, e_awr, e_wv, e_wr, e_arv, e_arr;
    bit awhs, whs, bhs, arhs, rhs;
    #1;
    e_awv = i_awvalid && (m_wr < MAX);
    e_awr = o_awready && (m_wr < MAX);
    e_wv  = i_wvalid  && (m_wb > 0);
    e_wr  = o_wready  && (m_wb > 0);
    e_arv = i_arvalid && (m_rd < MAX);
    e_arr = o_arready && (m_rd < MAX);
    chk("aw_gate", {o_awvalid, i_awready}, {e_awv, e_awr});
    chk("w_gate",  {o_wvalid, i_wready},   {e_wv, e_wr});
    chk("ar_gate", {o_arvalid, i_arready}, {e_arv, e_arr});
    chk("awch", o_awch, {i_awid, i_awprot, i_awaddr});
    chk("arch", o_arch, {i_arid, i_arprot, i_araddr});
    chk("wch",  o_wch,  {i_wstrb, i_wdata});
    chk("bch",  {i_bresp, i_bid}, o_bch);
    chk("rch",  {i_rresp, i_rid, i_rdata}, o_rch);
    chk("thru", {i_bvalid, o_bready, i_rvalid, o_rready, i_rlast, o_wlast},
                {o_bvalid, i_bready, o_rvalid, i_rready, o_rlast, i_wlast});
    awhs = e_awv && o_awready;
    whs  = e_wv && o_wready && i_wlast;
    bhs  = o_bvalid && i_bready;
    arhs = e_arv && o_arready;
    rhs  = o_rvalid && i_rready && o_rlast;
    @(posedge aclk); #1;
    if (bhs && m_wr == 0) m_perr = 1;
    if (rhs && m_rd == 0) m_perr = 1;
    if (awhs != bhs) m_wr = awhs ? m_wr + 1 : (m_wr > 0 ? m_wr - 1 : 0);
    if (arhs != rhs) m_rd = arhs ? m_rd + 1 : (m_rd > 0 ? m_rd - 1 : 0);
    m_wb = m_wb + int'(awhs) - int'(whs);
    chk("wr_ostd", o_wr_ostd, m_wr);
    chk("rd_ostd", o_rd_ostd, m_rd);
    chk("proto_err", o_proto_err, m_perr);
`ifndef AXICB_MST_TIMEOUT_EN
    chk("tmo_off", {o_wr_timeout, o_rd_timeout}, '0);
`endif
  endtask

  typedef struct {
    bit awv, awr, wv, bv, br;      // inputs
    bit x_awv, x_awr, x_wv;        // expected comb outputs
    int x_wr;                      // expected write count after the edge
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int beats;
    tbl[0]  = '{1,1,0,0,0, 1,1,0, 1};
    tbl[1]  = '{1,1,0,0,0, 1,1,0, 2};
    tbl[2]  = '{1,1,0,0,0, 1,1,0, 3};
    tbl[3]  = '{1,1,0,0,0, 1,1,0, 4};
    tbl[4]  = '{1,1,1,0,0, 0,0,1, 4};
    tbl[5]  = '{1,1,1,0,0, 0,0,1, 4};
    tbl[6]  = '{1,1,1,1,1, 0,0,1, 3};
    tbl[7]  = '{1,1,1,0,0, 1,1,1, 4};
    tbl[8]  = '{0,1,1,1,1, 0,0,1, 3};
    tbl[9]  = '{0,1,1,1,1, 0,1,0, 2};
    tbl[10] = '{1,1,0,1,1, 1,1,0, 2};
    tbl[11] = '{1,0,1,1,0, 1,0,1, 2};
    tbl[12] = '{0,0,1,1,1, 0,0,0, 1};
    tbl[13] = '{0,0,0,1,1, 0,0,0, 0};

    idle();
    arst = 1'b1;
    model_clear();
    @(posedge aclk); #1;
    do_reset();

    // ---------------- table: outstanding limit and W gating -------------
    for (int i = 0; i < 14; i++) begin
      i_awvalid = tbl[i].awv; o_awready = tbl[i].awr;
      i_wvalid  = tbl[i].wv;  o_wready  = 1'b1; i_wlast = 1'b1;
      o_bvalid  = tbl[i].bv;  i_bready  = tbl[i].br;
      #1;
      chk($sformatf("tbl%0d_awvalid", i), o_awvalid, tbl[i].x_awv);
      chk($sformatf("tbl%0d_awready", i), i_awready, tbl[i].x_awr);
      chk($sformatf("tbl%0d_wvalid", i),  o_wvalid,  tbl[i].x_wv);
      @(posedge aclk); #1;
      chk($sformatf("tbl%0d_wr_ostd", i), o_wr_ostd, tbl[i].x_wr);
    end
    do_reset();

    // ---------------- randomized legal traffic vs model ----------------
    for (int n = 0; n < 400; n++) begin
      i_awvalid = 1'($urandom); o_awready = 1'($urandom);
      i_awaddr = 8'($urandom); i_awid = 8'($urandom); i_awprot = 3'($urandom);
      i_awlen = 8'($urandom); i_awqos = 4'($urandom);
      i_wvalid = 1'($urandom); o_wready = 1'($urandom); i_wlast = 1'($urandom);
      i_wdata = 8'($urandom); i_wstrb = 1'($urandom);
      o_bvalid = (m_wr > m_wb) ? 1'($urandom) : 1'b0;
      i_bready = 1'($urandom); o_bch = 10'($urandom);
      i_arvalid = 1'($urandom); o_arready = 1'($urandom);
      i_araddr = 8'($urandom); i_arid = 8'($urandom); i_arprot = 3'($urandom);
      i_arsize = 3'($urandom);
      o_rvalid = (m_rd > 0) ? 1'($urandom) : 1'b0;
      i_rready = 1'($urandom); o_rlast = 1'($urandom); o_rch = 18'($urandom);
      cycle();
    end
    do_reset();

    // ---------------- W held until its AW is accepted -------------------
    i_wvalid = 1; o_wready = 1; i_wlast = 0;
    #1 chk("w_no_aw", {o_wvalid, i_wready}, 2'b00);
    cycle(); cycle();
    chk("w_no_aw_hold", o_wvalid, 1'b0);
    i_awvalid = 1; o_awready = 1; i_awlen = 8'd3;
    cycle();
    i_awvalid = 0;
    chk("w_open", o_wvalid, 1'b1);
    beats = 0;
    for (int b = 0; b < 4; b++) begin
      i_wlast = (b == 3);
      beats += int'(o_wvalid && o_wready);
      cycle();
    end
    chk("w_beats", beats, 4);
    chk("w_closed", o_wvalid, 1'b0);
    i_wvalid = 0; i_wlast = 0;

    // ---------------- AR and R-last in the same cycle --------------------
    i_arvalid = 1; o_arready = 1;
    cycle();
    chk("rd_one", o_rd_ostd, 1);
    o_rvalid = 1; i_rready = 1; o_rlast = 1;
    cycle();
    chk("ar_r_same", o_rd_ostd, 1);
    i_arvalid = 0;
    cycle();
    chk("rd_zero", o_rd_ostd, 0);
    o_rvalid = 0; o_rlast = 0;

    // ---------------- unsolicited B --------------------------------------
    o_bvalid = 1; i_bready = 1;
    cycle();                                 // retires the write above
    chk("wr_drained", o_wr_ostd, 0);
    chk("no_err_yet", o_proto_err, 1'b0);
    o_bch = 10'h2A5;
    #1 chk("b_fwd", {i_bvalid, i_bresp, i_bid}, {1'b1, 2'b10, 8'hA5});
    cycle();
    chk("perr_set", o_proto_err, 1'b1);
    chk("b_sat", o_wr_ostd, 0);
    o_bvalid = 0; i_bready = 0;
    cycle();
    chk("perr_sticky", o_proto_err, 1'b1);

    // ---------------- reset with traffic in flight ----------------------
    do_reset();
    i_awvalid = 1; o_awready = 1;
    repeat (3) cycle();
    chk("wr_three", o_wr_ostd, 3);
    i_wvalid = 1; o_wready = 1; i_arvalid = 1; o_arready = 1;
    #2 arst = 1'b1;
    #1;
    chk("rst_gate", {o_awvalid, i_awready, o_wvalid, i_wready, o_arvalid, i_arready}, '0);
    chk("rst_async_cnt", {o_wr_ostd, o_rd_ostd}, '0);
    model_clear();
    @(posedge aclk); #1;
    chk("rst_gate_hold", {o_awvalid, i_awready, o_arvalid, i_arready}, '0);
    arst = 1'b0;
    i_wvalid = 0; i_arvalid = 0;
    cycle();
    chk("resume", o_wr_ostd, 1);

`ifdef AXICB_MST_TIMEOUT_EN
    // ---------------- read stall timeout --------------------------------
    do_reset();
    i_arvalid = 1; o_arready = 1;
    cycle();
    i_arvalid = 0;
    repeat (TMO - 1) @(posedge aclk);
    #1 chk("tmo_early", o_rd_timeout, 1'b0);
    @(posedge aclk); #1;
    chk("tmo_set", o_rd_timeout, 1'b1);
    chk("tmo_wr_quiet", o_wr_timeout, 1'b0);
    i_timeout_clr = 1;
    @(posedge aclk); #1;
    i_timeout_clr = 0;
    chk("tmo_clr", o_rd_timeout, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
